// File: rtl/div_ctrl_pkg.sv
// ============================================================================
// Module   : div_ctrl_pkg
// Brief    : Shared types and constants for the DIV/DIVU sequencer.
//            State encodings, default datapath width and the funct codes
//            that the caller decodes into start_i / signed_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_ctrl_pkg;

  // Default operand/result width of the divide datapath.
  localparam int DIV_WIDTH = 32;

  // R-type funct codes for the two divide instructions. The decode into
  // start_i / signed_i is done by the Execute-stage caller.
  localparam logic [5:0] FUN_DIV  = 6'h1A;
  localparam logic [5:0] FUN_DIVU = 6'h1B;

  // Sequencer states, 2-bit encoded.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage : div_ctrl_pkg

`default_nettype wire

// File: rtl/div_ctrl_if.sv
// ============================================================================
// Module   : div_ctrl_if
// Brief    : Execute-stage <-> divide sequencer signal bundle. The pipeline
//            side (master) drives the request and flush; the sequencer side
//            (slave) returns stall, busy and the registered results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cancel_i;
  logic             stall_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;

  modport master (
    output start_i, signed_i, a_i, b_i, cancel_i,
    input  stall_o, busy_o, valid_o, quot_o, rem_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, cancel_i,
    output stall_o, busy_o, valid_o, quot_o, rem_o
  );

endinterface : div_ctrl_if

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module   : div_step
// Brief    : One radix-2 restoring divide iteration, purely combinational.
//            {r,q} is shifted left by one; if the shifted remainder is not
//            below |b| it is reduced by |b| and a 1 enters the quotient LSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [2*WIDTH-1:0] i_rq,   // {partial remainder, quotient}
  input  wire logic [WIDTH-1:0]   i_b,    // divisor magnitude
  output logic      [2*WIDTH-1:0] o_rq    // next {remainder, quotient}
);

  logic [WIDTH:0] w_shift;   // shifted remainder, one extra bit so 2|b|-1 fits
  logic [WIDTH:0] w_diff;    // trial subtraction; MSB is the borrow
  logic           w_ge;      // shifted remainder >= |b|

  // Trial subtract and restore: the borrow bit decides whether to keep it.
  always_comb begin
    w_shift = {i_rq[2*WIDTH-1:WIDTH], i_rq[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_b};
    w_ge    = ~w_diff[WIDTH];
    o_rq    = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
               i_rq[WIDTH-2:0], w_ge};
  end

endmodule : div_step

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
// Module   : div_ctrl
// Brief    : Multi-cycle DIV/DIVU sequencer beside the Execute stage. Stalls
//            the front of the pipe for WIDTH iterations of a restoring
//            divider, then presents quotient/remainder for one cycle.
//            Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the
//            iterations and goes straight from IDLE to DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input wire logic clk,
  input wire logic rst,       // asynchronous, active-low
  div_ctrl_if.slave bus
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_pr;        // partial remainder
  logic [WIDTH-1:0]   r_pq;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   r_absb;      // |b|
  logic [WIDTH-1:0]   r_a;         // raw dividend, returned as remainder on b==0
  logic               r_neg_q;     // signed op with differing operand signs
  logic               r_neg_r;     // signed op with negative dividend
  logic               r_bzero;     // divisor was zero
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;

  logic               w_load;      // accept a new operation this edge
  logic               w_step;      // perform one iteration this edge
  logic               w_finish;    // last iteration; load results this edge
  logic               w_fast;      // zero-divisor shortcut taken this edge
  logic               w_stall;
  logic               w_valid;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_b_zero;
  logic [2*WIDTH-1:0] w_rq_nxt;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_quot_fin;
  logic [WIDTH-1:0]   w_rem_fin;

  // Operand magnitudes and signs; signs only matter for DIV.
  always_comb begin
    w_a_neg  = bus.signed_i & bus.a_i[WIDTH-1];
    w_b_neg  = bus.signed_i & bus.b_i[WIDTH-1];
    w_abs_a  = w_a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
    w_abs_b  = w_b_neg ? (~bus.b_i + 1'b1) : bus.b_i;
    w_b_zero = (bus.b_i == '0);
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rq (({r_pr, r_pq})),
    .i_b  (r_absb),
    .o_rq (w_rq_nxt)
  );

  // Sign correction of the final iteration's result; a zero divisor forces
  // all-ones quotient and hands back the dividend untouched.
  always_comb begin
    w_r_mag    = w_rq_nxt[2*WIDTH-1:WIDTH];
    w_q_mag    = w_rq_nxt[WIDTH-1:0];
    w_quot_fin = r_neg_q ? (~w_q_mag + 1'b1) : w_q_mag;
    w_rem_fin  = r_neg_r ? (~w_r_mag + 1'b1) : w_r_mag;
    if (r_bzero) begin
      w_quot_fin = '1;
      w_rem_fin  = r_a;
    end
  end

  // Next-state and control decode; a flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_fast      = 1'b0;
    w_stall     = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (bus.start_i) begin
          w_load  = 1'b1;
          w_stall = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (w_b_zero) begin
            w_fast      = 1'b1;
            w_state_nxt = DIV_DONE;
          end else begin
            w_state_nxt = DIV_BUSY;
          end
`else
          w_state_nxt = DIV_BUSY;
`endif
        end
      end
      DIV_BUSY: begin
        w_stall = 1'b1;
        w_step  = 1'b1;
        if (r_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        // start_i is still the same instruction here, so it is not sampled.
        w_valid     = 1'b1;
        w_state_nxt = DIV_IDLE;
      end
      default: begin
        w_state_nxt = DIV_IDLE;
      end
    endcase
    if (bus.cancel_i) begin
      w_state_nxt = DIV_IDLE;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      w_fast      = 1'b0;
      w_stall     = 1'b0;
      w_valid     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch and iteration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_pr    <= '0;
      r_pq    <= '0;
      r_absb  <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
    end else if (w_load) begin
      r_cnt   <= CNT_LAST;
      r_pr    <= '0;
      r_pq    <= w_abs_a;
      r_absb  <= w_abs_b;
      r_a     <= bus.a_i;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_bzero <= w_b_zero;
    end else if (w_step) begin
      {r_pr, r_pq} <= w_rq_nxt;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Result registers: loaded on the DONE entry edge, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quot <= '0;
      r_rem  <= '0;
    end else if (w_finish) begin
      r_quot <= w_quot_fin;
      r_rem  <= w_rem_fin;
    end else if (w_fast) begin
      r_quot <= '1;
      r_rem  <= bus.a_i;
    end
  end

  // stall_o is combinational from start_i, so it is also masked by reset
  // to keep every output low while rst is asserted.
  assign bus.stall_o = w_stall & rst;
  assign bus.busy_o  = (r_state != DIV_IDLE);
  assign bus.valid_o = w_valid;
  assign bus.quot_o  = r_quot;
  assign bus.rem_o   = r_rem;

endmodule : div_ctrl

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// Module   : tb_div_ctrl
// Brief    : Scoreboard bench for div_ctrl. Driver pushes the expected
//            result and its cycle; an independent monitor pops and compares
//            whenever valid_o is seen. Honors DIV_ZERO_FAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ctrl;

  localparam int W    = 32;
  localparam int LAT  = W + 1;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] q;
    logic [31:0] r;
    string       nm;
  } exp_t;

  typedef struct {
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    string       nm;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];
  vec_t tbl[9];

  div_ctrl_if #(.WIDTH(W)) bus ();

  div_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every valid_o must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_o !== 1'b0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid: got valid_o=%b, want no result (cycle %0d)",
                 bus.valid_o, cyc);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.nm, "_quot"}, bus.quot_o, e.q);
        chk({e.nm, "_rem"}, bus.rem_o, e.r);
      end
    end
  end

  // Issue one divide at +1 of the current cycle; returns at +1 of the cycle
  // after DONE with start_i dropped.
  task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r,
                        input int lat, input string nm);
    exp_t e;
    int   n;
    bit   done;
    bus.start_i  = 1'b1;
    bus.signed_i = sg;
    bus.a_i      = a;
    bus.b_i      = b;
    e.cyc = cyc + lat;
    e.q   = q;
    e.r   = r;
    e.nm  = nm;
    sb.push_back(e);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.stall_o === 1'b1) n++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got stall_o high 100 cycles, want drop after %0d", nm, lat);
    end
    chk({nm, "_stall_cycles"}, 32'(n), 32'(lat));
    bus.start_i = 1'b0;
  endtask

  // One idle cycle: state back in IDLE, results still held.
  task automatic idle_chk(input logic [31:0] q, input logic [31:0] r, input string nm);
    @(negedge clk);
    chk({nm, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
    chk({nm, "_idle_stall"}, 32'(bus.stall_o), 32'd0);
    chk({nm, "_hold_quot"}, bus.quot_o, q);
    chk({nm, "_hold_rem"}, bus.rem_o, r);
    @(posedge clk); #1;
  endtask

  task automatic outs_zero(input string nm);
    chk({nm, "_stall"}, 32'(bus.stall_o), 32'd0);
    chk({nm, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({nm, "_valid"}, 32'(bus.valid_o), 32'd0);
    chk({nm, "_quot"}, bus.quot_o, 32'd0);
    chk({nm, "_rem"}, bus.rem_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time 100000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          LAT,  "divu_100_7"};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  LAT,  "div_m7_2"};
    tbl[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          LAT,  "div_ovf"};
    tbl[3] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  ZLAT, "divu_by0"};
    tbl[4] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  ZLAT, "div_by0"};
    tbl[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          LAT,  "div_7_m2"};
    tbl[6] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  LAT,  "div_m7_m2"};
    tbl[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          LAT,  "divu_max_1"};
    tbl[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  LAT,  "divu_big"};

    rst          = 1'b0;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.cancel_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    outs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, each followed by an idle/hold check.
    foreach (tbl[k]) begin
      do_div(tbl[k].sg, tbl[k].a, tbl[k].b, tbl[k].q, tbl[k].r, tbl[k].lat, tbl[k].nm);
      idle_chk(tbl[k].q, tbl[k].r, tbl[k].nm);
    end

    // Cancel at cycle 10 of 100/7, restart 9/3 at cycle 11 (result at 44).
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i      = 32'd100;
    bus.b_i      = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    bus.cancel_i = 1'b1;
    @(negedge clk);
    chk("cancel_stall", 32'(bus.stall_o), 32'd0);
    chk("cancel_valid", 32'(bus.valid_o), 32'd0);
    chk("cancel_busy_before", 32'(bus.busy_o), 32'd1);
    @(posedge clk); #1;
    bus.cancel_i = 1'b0;
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LAT, "restart_9_3");
    idle_chk(32'd3, 32'd0, "restart_9_3");

    // Cancel and start in the same IDLE cycle: cancel wins.
    bus.start_i  = 1'b1;
    bus.cancel_i = 1'b1;
    bus.a_i      = 32'd50;
    bus.b_i      = 32'd5;
    @(negedge clk);
    chk("cancel_start_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    @(negedge clk);
    chk("cancel_start_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1;

    // Reset asserted at cycle 5 of a BUSY operation with start_i held high.
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i      = 32'd100;
    bus.b_i      = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    outs_zero("midrst");
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: 20/6 at cycle 0 -> 33, 21/4 at cycle 34 -> 67.
    do_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, LAT, "b2b_20_6");
    do_div(1'b0, 32'd21, 32'd4, 32'd5, 32'd1, LAT, "b2b_21_4");
    idle_chk(32'd5, 32'd1, "b2b_21_4");
    repeat (3) begin @(posedge clk); #1; end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_div_ctrl

`default_nettype wire
